// File: rtl/qtile_row_packer.sv
// Tile row packer: latches a per-row scale set, packs one quantized tile from a lane
// stream into a row buffer, then replays it row by row with each row's scale.
module qtile_row_packer #(
  parameter int unsigned BIT_NUM   = 8,
  parameter int unsigned MAT_SIZE  = 16,
  parameter int unsigned FP_DATA_W = 32,
  parameter int unsigned FP_EXP_W  = 8,
  parameter int unsigned FP_MANT_W = 23,
  parameter int unsigned LANES_NUM = 16,
  localparam int unsigned ROW_W    = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scl_valid_i,
  output logic                          scl_ready_o,
  input  logic [FP_MANT_W*MAT_SIZE-1:0] mant_scale_i,
  input  logic [FP_EXP_W*MAT_SIZE-1:0]  exp_scale_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [LANES_NUM*FP_DATA_W-1:0] s_data_i,
  output logic                          r_valid_o,
  input  logic                          r_ready_i,
  output logic [MAT_SIZE*BIT_NUM-1:0]   r_data_o,
  output logic [FP_MANT_W-1:0]          r_mant_o,
  output logic [FP_EXP_W-1:0]           r_exp_o,
  output logic [ROW_W-1:0]              r_idx_o,
  output logic                          r_last_o,
  output logic                          tile_done_o,
  output logic                          ovf_err_o
);

  localparam int unsigned ELEMS    = MAT_SIZE * MAT_SIZE;
  localparam int unsigned IN_BEATS = (ELEMS + LANES_NUM - 1) / LANES_NUM;
  localparam int unsigned BEAT_W   = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int unsigned EIDX_W   = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int unsigned ROW_BITS = MAT_SIZE * BIT_NUM;
  localparam int unsigned EXT_W    = FP_DATA_W - BIT_NUM + 1;

  typedef enum logic [1:0] {
    S_SCALE   = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic                          ovf_q, ovf_d;
  logic                          done_q, done_d;

  logic [BIT_NUM-1:0]            elem_q [ELEMS];
  logic [FP_MANT_W*MAT_SIZE-1:0] mant_q;
  logic [FP_EXP_W*MAT_SIZE-1:0]  exp_q;
  logic [ROW_BITS-1:0]           hold_data_q;
  logic [FP_MANT_W-1:0]          hold_mant_q;
  logic [FP_EXP_W-1:0]           hold_exp_q;

  logic                          scl_fire, s_fire;
  logic [LANES_NUM-1:0]          lane_we, lane_bad;
  logic [EIDX_W-1:0]             lane_idx [LANES_NUM];
  logic [BIT_NUM-1:0]            lane_val [LANES_NUM];
  logic [EXT_W-1:0]              lane_ext [LANES_NUM];
  logic [ROW_BITS-1:0]           row_data;
  logic [FP_MANT_W-1:0]          cur_mant;
  logic [FP_EXP_W-1:0]           cur_exp;

  // Handshakes are decoded from state only, so they are mutually exclusive
  assign scl_ready_o = (state_q == S_SCALE);
  assign s_ready_o   = (state_q == S_COLLECT);
  assign r_valid_o   = (state_q == S_DRAIN);
  assign scl_fire    = scl_ready_o & scl_valid_i;
  assign s_fire      = s_ready_o & s_valid_i;

  // Per-lane element index, narrowed value and sign-extension range check
  always_comb begin
    for (int l = 0; l < LANES_NUM; l++) begin
      lane_idx[l] = EIDX_W'(32'(beat_q) * LANES_NUM + 32'(l));
      lane_val[l] = s_data_i[l*FP_DATA_W +: BIT_NUM];
      lane_ext[l] = s_data_i[l*FP_DATA_W + BIT_NUM - 1 +: EXT_W];
      lane_we[l]  = s_fire && ((32'(beat_q) * LANES_NUM + 32'(l)) < ELEMS);
      lane_bad[l] = lane_we[l] && (lane_ext[l] != '0) && (lane_ext[l] != '1);
    end
  end

  // Current row view selected by the row counter
  always_comb begin
    row_data = '0;
    for (int c = 0; c < MAT_SIZE; c++) begin
      row_data[c*BIT_NUM +: BIT_NUM] = elem_q[EIDX_W'(32'(row_q) * MAT_SIZE + 32'(c))];
    end
    cur_mant = mant_q[32'(row_q)*FP_MANT_W +: FP_MANT_W];
    cur_exp  = exp_q[32'(row_q)*FP_EXP_W +: FP_EXP_W];
  end

  // Outside the drain phase the last replayed row is presented unchanged
  assign r_data_o    = r_valid_o ? row_data : hold_data_q;
  assign r_mant_o    = r_valid_o ? cur_mant : hold_mant_q;
  assign r_exp_o     = r_valid_o ? cur_exp  : hold_exp_q;
  assign r_idx_o     = row_q;
  assign r_last_o    = r_valid_o && (row_q == ROW_W'(MAT_SIZE - 1));
  assign tile_done_o = done_q;
  assign ovf_err_o   = ovf_q;

  // Next-state logic for scale -> collect -> drain sequencing
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    ovf_d   = ovf_q | (|lane_bad);
    done_d  = 1'b0;
    case (state_q)
      S_SCALE: begin
        if (scl_valid_i) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (s_valid_i) begin
          if (beat_q == BEAT_W'(IN_BEATS - 1)) begin
            beat_d  = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_ready_i) begin
          if (row_q == ROW_W'(MAT_SIZE - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = S_SCALE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = S_SCALE;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SCALE;
      beat_q  <= '0;
      row_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Scale latch, row buffer writes and last-row snapshot (contents need no reset)
  always_ff @(posedge clk) begin
    if (scl_fire) begin
      mant_q <= mant_scale_i;
      exp_q  <= exp_scale_i;
    end
    for (int l = 0; l < LANES_NUM; l++) begin
      if (lane_we[l]) elem_q[lane_idx[l]] <= lane_val[l];
    end
    if (done_d) begin
      hold_data_q <= row_data;
      hold_mant_q <= cur_mant;
      hold_exp_q  <= cur_exp;
    end
  end

endmodule

// File: tb/tb_qtile_row_packer.sv
// Bench for qtile_row_packer: two 4x4 instances (3 lanes with padding, 4 lanes exact)
// driven with random tiles and checked against an element-level reference model.
module tb_qtile_row_packer;

  localparam int unsigned MS = 4;
  localparam int unsigned BN = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned NE = MS * MS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0]          scl_valid, s_valid, r_ready;
  logic [1:0]          scl_ready, s_ready, r_valid, r_last, tile_done, ovf;
  logic [MW*MS-1:0]    mant_scale;
  logic [EW*MS-1:0]    exp_scale;
  logic [3*DW-1:0]     s_data0;
  logic [4*DW-1:0]     s_data1;
  logic [MS*BN-1:0]    r_data [2];
  logic [MW-1:0]       r_mant [2];
  logic [EW-1:0]       r_exp  [2];
  logic [1:0]          r_idx  [2];

  qtile_row_packer #(.BIT_NUM(BN), .MAT_SIZE(MS), .FP_DATA_W(DW), .FP_EXP_W(EW),
                     .FP_MANT_W(MW), .LANES_NUM(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .scl_valid_i(scl_valid[0]), .scl_ready_o(scl_ready[0]),
    .mant_scale_i(mant_scale), .exp_scale_i(exp_scale),
    .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]), .s_data_i(s_data0),
    .r_valid_o(r_valid[0]), .r_ready_i(r_ready[0]), .r_data_o(r_data[0]),
    .r_mant_o(r_mant[0]), .r_exp_o(r_exp[0]), .r_idx_o(r_idx[0]),
    .r_last_o(r_last[0]), .tile_done_o(tile_done[0]), .ovf_err_o(ovf[0])
  );

  qtile_row_packer #(.BIT_NUM(BN), .MAT_SIZE(MS), .FP_DATA_W(DW), .FP_EXP_W(EW),
                     .FP_MANT_W(MW), .LANES_NUM(4)) u_dut_l4 (
    .clk(clk), .rst(rst),
    .scl_valid_i(scl_valid[1]), .scl_ready_o(scl_ready[1]),
    .mant_scale_i(mant_scale), .exp_scale_i(exp_scale),
    .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]), .s_data_i(s_data1),
    .r_valid_o(r_valid[1]), .r_ready_i(r_ready[1]), .r_data_o(r_data[1]),
    .r_mant_o(r_mant[1]), .r_exp_o(r_exp[1]), .r_idx_o(r_idx[1]),
    .r_last_o(r_last[1]), .tile_done_o(tile_done[1]), .ovf_err_o(ovf[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference tile: full-width lane value per element plus per-row scales
  logic [DW-1:0] tile_e [NE];
  logic [MW-1:0] tile_m [MS];
  logic [EW-1:0] tile_x [MS];
  bit            ovf_m  [2];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected packed row: each element reduced modulo 2^BIT_NUM, column c at byte c
  function automatic logic [MS*BN-1:0] exp_row(input int r);
    logic [MS*BN-1:0] res;
    res = '0;
    for (int c = 0; c < MS; c++) res[c*BN +: BN] = BN'(tile_e[r*MS + c] % 256);
    return res;
  endfunction

  function automatic bit in_range(input logic [DW-1:0] v);
    return ($signed(v) >= -128) && ($signed(v) <= 127);
  endfunction

  // kind 0: random in-range; 1: random plus one 0x80 element; 2: e-8 pattern, exp 100+k
  task automatic gen_tile(input int kind);
    for (int e = 0; e < NE; e++) begin
      if (kind == 2) tile_e[e] = DW'(e - 8);
      else           tile_e[e] = DW'(int'($urandom_range(0, 255)) - 128);
    end
    if (kind == 1) tile_e[$urandom_range(0, NE-1)] = 32'h0000_0080;
    for (int k = 0; k < MS; k++) begin
      tile_m[k] = MW'($urandom);
      tile_x[k] = (kind == 2) ? EW'(100 + k) : EW'($urandom);
    end
  endtask

  task automatic set_lane(input int sel, input int l, input logic [DW-1:0] v);
    if (sel == 0) s_data0[l*DW +: DW] = v;
    else          s_data1[l*DW +: DW] = v;
  endtask

  // mode 0: r_ready always 1; 1: toggles 0/1; 2: random
  task automatic send_tile(input int sel, input int mode);
    int nl, nb, row, cyc, e;
    bit rdy;
    nl = (sel == 0) ? 3 : 4;
    nb = (NE + nl - 1) / nl;
    @(negedge clk);
    chk("scl_ready_idle", 64'(scl_ready[sel]), 64'd1);
    chk("s_ready_idle",   64'(s_ready[sel]),   64'd0);
    chk("r_valid_idle",   64'(r_valid[sel]),   64'd0);
    for (int k = 0; k < MS; k++) begin
      mant_scale[k*MW +: MW] = tile_m[k];
      exp_scale[k*EW +: EW]  = tile_x[k];
    end
    for (int l = 0; l < nl; l++) set_lane(sel, l, 32'h1234_5678);
    scl_valid[sel] = 1'b1;
    s_valid[sel]   = 1'b1;
    @(negedge clk);
    scl_valid[sel] = 1'b0;
    s_valid[sel]   = 1'b0;
    chk("s_ready_collect",   64'(s_ready[sel]),   64'd1);
    chk("scl_ready_collect", 64'(scl_ready[sel]), 64'd0);
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid[sel] = 1'b0;
        @(negedge clk);
      end
      for (int l = 0; l < nl; l++) begin
        e = b * nl + l;
        set_lane(sel, l, (e < NE) ? tile_e[e] : 32'h7FFF_FFFF);
      end
      s_valid[sel] = 1'b1;
      @(negedge clk);
    end
    for (int e2 = 0; e2 < NE; e2++) if (!in_range(tile_e[e2])) ovf_m[sel] = 1'b1;
    // Stray requests during drain must be ignored
    for (int l = 0; l < nl; l++) set_lane(sel, l, 32'h1234_5678);
    mant_scale     = (MW*MS)'({$urandom, $urandom, $urandom});
    exp_scale      = (EW*MS)'($urandom);
    scl_valid[sel] = 1'b1;
    row = 0;
    cyc = 0;
    while (row < MS && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 0) chk("zero_bubble_idx", 64'(r_idx[sel]), 64'd0);
      chk("r_valid_drain", 64'(r_valid[sel]),   64'd1);
      chk("r_data",        64'(r_data[sel]),    64'(exp_row(row)));
      chk("r_mant",        64'(r_mant[sel]),    64'(tile_m[row]));
      chk("r_exp",         64'(r_exp[sel]),     64'(tile_x[row]));
      chk("r_idx",         64'(r_idx[sel]),     64'(row));
      chk("r_last",        64'(r_last[sel]),    64'(row == MS - 1));
      chk("s_ready_drain", 64'(s_ready[sel]),   64'd0);
      chk("scl_rdy_drain", 64'(scl_ready[sel]), 64'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      r_ready[sel] = rdy;
      cyc++;
      if (rdy) row++;
    end
    chk("drain_rows", 64'(row), 64'(MS));
    if (mode == 0) chk("drain_cycles", 64'(cyc), 64'(MS));
    if (mode == 1) chk("drain_cycles", 64'(cyc), 64'(2*MS));
    @(negedge clk);
    r_ready[sel]   = 1'b0;
    s_valid[sel]   = 1'b0;
    scl_valid[sel] = 1'b0;
    chk("tile_done",      64'(tile_done[sel]), 64'd1);
    chk("scl_ready_next", 64'(scl_ready[sel]), 64'd1);
    chk("r_valid_after",  64'(r_valid[sel]),   64'd0);
    chk("r_data_hold",    64'(r_data[sel]),    64'(exp_row(MS-1)));
    chk("r_mant_hold",    64'(r_mant[sel]),    64'(tile_m[MS-1]));
    chk("ovf_err",        64'(ovf[sel]),       64'(ovf_m[sel]));
    @(negedge clk);
    chk("tile_done_pulse", 64'(tile_done[sel]), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    scl_valid = '0; s_valid = '0; r_ready = '0;
    mant_scale = '0; exp_scale = '0; s_data0 = '0; s_data1 = '0;
    ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_scl_ready", 64'(scl_ready[i]), 64'd1);
      chk("rst_s_ready",   64'(s_ready[i]),   64'd0);
      chk("rst_r_valid",   64'(r_valid[i]),   64'd0);
      chk("rst_ovf",       64'(ovf[i]),       64'd0);
      chk("rst_done",      64'(tile_done[i]), 64'd0);
    end

    // Reset in the middle of collection, with beat 3 being offered
    gen_tile(0);
    scl_valid[0] = 1'b1;
    @(negedge clk);
    scl_valid[0] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int l = 0; l < 3; l++) set_lane(0, l, 32'h0000_1000);
      s_valid[0] = 1'b1;
      @(negedge clk);
    end
    chk("mid_ovf_set",   64'(ovf[0]),     64'd1);
    chk("mid_s_ready",   64'(s_ready[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_valid[0] = 1'b0;
    chk("mid_rst_scl_ready", 64'(scl_ready[0]), 64'd1);
    chk("mid_rst_s_ready",   64'(s_ready[0]),   64'd0);
    chk("mid_rst_ovf",       64'(ovf[0]),       64'd0);
    chk("mid_rst_r_valid",   64'(r_valid[0]),   64'd0);
    send_tile(0, 0);

    // Fixed e-8 pattern on the 4-lane instance
    gen_tile(2);
    send_tile(1, 0);

    // Toggled ready on the padded 3-lane instance
    gen_tile(0);
    send_tile(0, 1);

    // Out-of-range lane sets the sticky error, which survives the next tile
    gen_tile(1);
    send_tile(0, 2);
    gen_tile(0);
    send_tile(0, 0);

    // Back-to-back random tiles with random ready patterns
    for (int t = 0; t < 6; t++) begin
      gen_tile((t == 3) ? 1 : 0);
      send_tile(t % 2, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
